// File: rtl/bcd_scan_display_if.sv
// Digit-word input and multiplexed display output bundle for bcd_scan_display.
// The master side drives digit codes and load; the slave side drives the display lines.
interface bcd_scan_display_if;
    logic       load;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       lzb;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;
    logic       pending;

    modport master (
        output load, d3, d2, d1, d0, lzb,
        input  seg, an, frame, pending
    );

    modport slave (
        input  load, d3, d2, d1, d0, lzb,
        output seg, an, frame, pending
    );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit seven-segment driver with frame-aligned word commit
// and leading-zero blanking. Segment and anode lines are active-low.
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic              clk,
    input logic              rst,
    bcd_scan_display_if.slave bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0] CODE_BLANK = 4'd15;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic             tick;
    logic             wrap;

    logic [15:0]      pend_word_q;
    logic [15:0]      act_word_q;
    logic             pending_q;
    logic             frame_q;

    logic [3:0]       an_q;
    logic [3:0]       an_d;
    logic [7:0]       seg_q;
    logic [7:0]       seg_d;
    logic [3:0]       cur_code;
    logic [3:0]       blank_vec;

    // gfedcba, active-low
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        unique case (code)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            4'd10:   g = 7'h3F;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    assign tick = (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            if (tick) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // A load on the wrap edge still lets the older pending word commit first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_word_q <= {4{CODE_BLANK}};
            act_word_q  <= {4{CODE_BLANK}};
            pending_q   <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            if (wrap && pending_q) begin
                act_word_q <= pend_word_q;
            end
            if (bus.load) begin
                pend_word_q <= {bus.d3, bus.d2, bus.d1, bus.d0};
            end
            pending_q <= bus.load | (pending_q & ~wrap);
            frame_q   <= wrap;
        end
    end

    // Zeros are blanked from the left until the first non-zero code; d0 always shows.
    always_comb begin
        blank_vec    = 4'b0000;
        blank_vec[3] = bus.lzb && (act_word_q[15:12] == 4'd0);
        blank_vec[2] = blank_vec[3] && (act_word_q[11:8] == 4'd0);
        blank_vec[1] = blank_vec[2] && (act_word_q[7:4] == 4'd0);
    end

    always_comb begin
        cur_code = act_word_q[{idx_q, 2'b00} +: 4];
        an_d     = 4'b1111;
        an_d[idx_q] = 1'b0;
        if (blank_vec[idx_q]) begin
            seg_d = {1'b1, glyph(CODE_BLANK)};
        end else begin
            seg_d = {1'b1, glyph(cur_code)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 4'b1111;
            seg_q <= 8'hFF;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.frame   = frame_q;
    assign bus.pending = pending_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: stimulus pushes expected {an, seg} per digit slot,
// a monitor pops and compares on every anode change and checks frame spacing.
module tb_bcd_scan_display;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int          FRAME_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_scan_display_if bus();

    bcd_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [11:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each anode change is one presented digit slot.
    logic [3:0] prev_an = 4'b1111;
    int cyc = 0;
    int last_frame = -1;
    always @(negedge clk) begin
        logic [11:0] e;
        cyc++;
        if (bus.an !== prev_an) begin
            if (sb_q.size() == 0) begin
                check("unexpected_digit", {28'd0, bus.an}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("an", {28'd0, bus.an}, {28'd0, e[11:8]});
                check($sformatf("seg[an=%b]", e[11:8]), {24'd0, bus.seg}, {24'd0, e[7:0]});
            end
        end
        prev_an = bus.an;
        if (rst) begin
            last_frame = -1;
        end else if (bus.frame === 1'b1) begin
            if (last_frame >= 0) check("frame_period", cyc - last_frame, FRAME_CYC);
            last_frame = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] a3, a2, a1, a0);
        bus.d3   = a3;
        bus.d2   = a2;
        bus.d1   = a1;
        bus.d0   = a0;
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame !== 1'b1 && n < 40);
        if (bus.frame !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: no frame pulse within %0d cycles, expected one", n);
        end
    endtask

    // Expected segments listed d0..d3 in scan order; ndig < 4 for a frame cut short.
    task automatic push_frame(input logic [7:0] s0, s1, s2, s3, input int ndig);
        logic [7:0] s[4];
        logic [3:0] a;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < ndig; i++) begin
            a = 4'b1111;
            a[i] = 1'b0;
            sb_q.push_back({a, s[i]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load = 1'b0;
        bus.d3   = 4'd0;
        bus.d2   = 4'd0;
        bus.d1   = 4'd0;
        bus.d0   = 4'd0;
        bus.lzb  = 1'b0;

        tick(3);
        check("rst_an", {28'd0, bus.an}, 32'hF);
        check("rst_seg", {24'd0, bus.seg}, 32'hFF);
        check("rst_frame", {31'd0, bus.frame}, 32'd0);
        check("rst_pending", {31'd0, bus.pending}, 32'd0);

        // Frame 0: blank, word 1,2,3,4 loaded mid-frame
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4);
        rst = 1'b0;
        tick(6);
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        check("pending_after_load", {31'd0, bus.pending}, 32'd1);
        wait_frame();
        check("pending_after_commit1", {31'd0, bus.pending}, 32'd0);
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4);

        // Frame 1: two loads, last one wins
        tick(3);
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        tick(1);
        do_load(4'd5, 4'd6, 4'd7, 4'd8);
        check("pending_overwrite", {31'd0, bus.pending}, 32'd1);
        wait_frame();
        check("pending_after_commit2", {31'd0, bus.pending}, 32'd0);
        push_frame(8'h80, 8'hF8, 8'h82, 8'h92, 4);

        // Frame 2: word A mid-frame, word B on the wrap edge itself
        tick(5);
        do_load(4'd9, 4'd8, 4'd7, 4'd6);
        tick(9);
        do_load(4'd4, 4'd3, 4'd2, 4'd1);
        wait_frame();
        check("pending_held_across_wrap", {31'd0, bus.pending}, 32'd1);
        push_frame(8'h82, 8'hF8, 8'h80, 8'h90, 4);
        wait_frame();
        check("pending_after_commit_b", {31'd0, bus.pending}, 32'd0);
        push_frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 4);

        // "-7" with blanking
        tick(4);
        bus.lzb = 1'b1;
        do_load(4'd0, 4'd0, 4'd10, 4'd7);
        wait_frame();
        push_frame(8'hF8, 8'hBF, 8'hFF, 8'hFF, 4);

        // All zeros with blanking: only d0 lit
        tick(4);
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame();
        push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4);

        // Blanking off: zeros shown literally
        tick(4);
        do_load(4'd0, 4'd10, 4'd0, 4'd0);
        wait_frame();
        bus.lzb = 1'b0;
        push_frame(8'hC0, 8'hC0, 8'hBF, 8'hC0, 4);

        // Blank code counts as non-zero, so d1's zero stays visible
        tick(4);
        do_load(4'd15, 4'd12, 4'd0, 4'd3);
        wait_frame();
        bus.lzb = 1'b1;
        push_frame(8'hB0, 8'hC0, 8'hFF, 8'hFF, 2);

        // Reset partway through digit 1
        tick(6);
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
        sb_q.push_back({4'b1111, 8'hFF});
        rst = 1'b1;
        #1;
        check("midrst_an", {28'd0, bus.an}, 32'hF);
        check("midrst_seg", {24'd0, bus.seg}, 32'hFF);
        check("midrst_frame", {31'd0, bus.frame}, 32'd0);
        check("midrst_pending", {31'd0, bus.pending}, 32'd0);
        tick(1);
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 4);
        rst = 1'b0;
        wait_frame();
        check("pending_after_rst", {31'd0, bus.pending}, 32'd0);
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
